// File: rtl/ps2_player_controls.sv
// PS/2 keyboard receiver and set-2 scan-code decoder that drives two players' held-key levels.
// Optional build macro PS2_FIRE_ONESHOT_EN turns fire1/fire2 into one-clk pulses on a fresh press.
module ps2_player_controls #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       up1,
    output logic       down1,
    output logic       left1,
    output logic       right1,
    output logic       fire1,
    output logic       up2,
    output logic       down2,
    output logic       left2,
    output logic       right2,
    output logic       fire2,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err,
    output logic [1:0] rx_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    // Key vector order: up1 down1 left1 right1 fire1 up2 down2 left2 right2 fire2.
    localparam int K_FIRE1 = 4;
    localparam int K_FIRE2 = 9;

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic [1:0] raw_s;
    logic [1:0] filt;
    logic       clk_filt_d;
    logic       fall;
    logic       data_bit;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        par_ok_q;
    logic [TW-1:0] to_cnt_q;
    logic        timeout;

    logic        accept;
    logic        err_now;
    logic        is_prefix;
    logic [9:0]  hit;
    logic [9:0]  keys_q;
    logic        ext_q;
    logic        brk_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign raw_s = {data_sync[1], clk_sync[1]};

    // Index 0 filters the clock pin, index 1 the data pin; idle bus level is high.
    for (genvar g = 0; g < 2; g++) begin : g_filt
        logic [FW-1:0] cnt;
        logic          lvl;

        always_ff @(posedge clk or negedge clrn) begin
            if (!clrn) begin
                cnt <= '0;
                lvl <= 1'b1;
            end else if (raw_s[g] == lvl) begin
                cnt <= '0;
            end else if (cnt == FILT_LAST) begin
                cnt <= '0;
                lvl <= raw_s[g];
            end else begin
                cnt <= cnt + FW'(1);
            end
        end

        assign filt[g] = lvl;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) clk_filt_d <= 1'b1;
        else       clk_filt_d <= filt[0];
    end

    assign fall     = clk_filt_d & ~filt[0];
    assign data_bit = filt[1];
    assign timeout  = (state_q != S_IDLE) && !fall && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else if (fall) begin
            case (state_q)
                S_IDLE:   if (!data_bit) state_d = S_DATA;
                S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        accept  = (state_q == S_STOP) && fall && data_bit && par_ok_q;
        err_now = timeout || ((state_q == S_STOP) && fall && !(data_bit && par_ok_q));
    end

    assign rx_state = state_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_ok_q  <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            if (state_q == S_IDLE || fall) to_cnt_q <= '0;
            else                           to_cnt_q <= to_cnt_q + TW'(1);
            if (fall) begin
                case (state_q)
                    S_IDLE: bit_cnt_q <= '0;
                    S_DATA: begin
                        shift_q   <= {data_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    S_PARITY: par_ok_q <= ^{shift_q, data_bit};
                    default: ;
                endcase
            end
        end
    end

    assign is_prefix = (shift_q == 8'hE0) || (shift_q == 8'hF0);

    always_comb begin
        hit = '0;
        if (ext_q) begin
            case (shift_q)
                8'h75:   hit[5] = 1'b1;
                8'h72:   hit[6] = 1'b1;
                8'h6B:   hit[7] = 1'b1;
                8'h74:   hit[8] = 1'b1;
                8'h5A:   hit[9] = 1'b1;
                default: ;
            endcase
        end else begin
            case (shift_q)
                8'h1D:   hit[0] = 1'b1;
                8'h1B:   hit[1] = 1'b1;
                8'h1C:   hit[2] = 1'b1;
                8'h23:   hit[3] = 1'b1;
                8'h29:   hit[4] = 1'b1;
                8'h5A:   hit[9] = 1'b1;
                default: ;
            endcase
        end
    end

    // Flags and keys change only on accepted bytes, so frame errors leave them untouched.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            scan_code  <= 8'h00;
            keys_q     <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            scan_valid <= accept;
            frame_err  <= err_now;
            if (accept) begin
                scan_code <= shift_q;
                if (shift_q == 8'hE0) begin
                    ext_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_q <= 1'b1;
                end else begin
                    keys_q <= (keys_q & ~hit) | (hit & {10{~brk_q}});
                    ext_q  <= 1'b0;
                    brk_q  <= 1'b0;
                end
            end
        end
    end

    assign up1    = keys_q[0];
    assign down1  = keys_q[1];
    assign left1  = keys_q[2];
    assign right1 = keys_q[3];
    assign up2    = keys_q[5];
    assign down2  = keys_q[6];
    assign left2  = keys_q[7];
    assign right2 = keys_q[8];

`ifdef PS2_FIRE_ONESHOT_EN
    logic [1:0] fire_pulse_q;

    // keys_q still tracks the held fire state; a pulse fires only on a press from released.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fire_pulse_q <= 2'b00;
        end else begin
            fire_pulse_q <= 2'b00;
            if (accept && !is_prefix) begin
                fire_pulse_q[0] <= hit[K_FIRE1] & ~brk_q & ~keys_q[K_FIRE1];
                fire_pulse_q[1] <= hit[K_FIRE2] & ~brk_q & ~keys_q[K_FIRE2];
            end
        end
    end

    assign fire1 = fire_pulse_q[0];
    assign fire2 = fire_pulse_q[1];
`else
    logic unused_prefix;
    assign unused_prefix = is_prefix;
    assign fire1 = keys_q[K_FIRE1];
    assign fire2 = keys_q[K_FIRE2];
`endif

endmodule
